// File: rtl/lcd_hd44780_responder_if.sv
// Pin-side and inspection signals of the HD44780 responder. The tristate LCD_data
// bus stays a plain inout port on the responder itself.
interface lcd_hd44780_responder_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [6:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [6:0] ac;
  logic       busy;
  logic       disp_on;
  logic       cursor_on;
  logic       blink_on;
  logic       two_line;
  logic [5:0] shift_ofs;
  logic       protocol_err;

  modport master (
    output LCD_E, LCD_RS, LCD_RW, dbg_addr,
    input  dbg_data, ac, busy, disp_on, cursor_on, blink_on, two_line, shift_ofs, protocol_err
  );

  modport slave (
    input  LCD_E, LCD_RS, LCD_RW, dbg_addr,
    output dbg_data, ac, busy, disp_on, cursor_on, blink_on, two_line, shift_ofs, protocol_err
  );
endinterface

// File: rtl/lcd_hd44780_responder.sv
// Cycle-based HD44780 character LCD responder: DDRAM/CGRAM, address counter, busy model.
// Build option LCD_RESP_BUSY_CHECK_EN drops writes committed while busy and flags protocol_err.
module lcd_hd44780_responder #(
  parameter int unsigned BUSY_CYCLES      = 40,
  parameter int unsigned BUSY_LONG_CYCLES = 1640
) (
  input  logic                           clk,
  input  logic                           reset_n,
  lcd_hd44780_responder_if.slave         lcd,
  inout  wire [7:0]                      LCD_data
);

  localparam int unsigned DD_CELLS     = 80;
  localparam int unsigned SHIFT_MOD    = 40;
  localparam int unsigned CLEAR_CYCLES = (BUSY_LONG_CYCLES > 80) ? BUSY_LONG_CYCLES : 80;
  localparam int unsigned MAX_CYCLES   = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CNT_W        = $clog2(MAX_CYCLES + 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e           state_q, state_d;
  logic [6:0]       sweep_idx_q, sweep_idx_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             busy_q, busy_d;
  logic             e_q;
  logic             rs_q, rw_q;
  logic [7:0]       data_q;
  logic [6:0]       ac_q, ac_d;
  logic             ac_cg_q, ac_cg_d;
  logic             id_q, id_d, s_q, s_d;
  logic             d_q, d_d, c_q, c_d, b_q, b_d;
  logic             n_q, n_d;
  logic [5:0]       shift_q, shift_d;
  logic             perr_q, perr_d;

  logic [7:0]       ddram_q [DD_CELLS];
  logic [7:0]       cgram_q [64];

  logic             commit_c, wr_commit_c, drop_c, wr_ok_c;
  logic             dd_we, cg_we, sw_we;
  logic [6:0]       dd_widx, sw_idx;
  logic [5:0]       cg_waddr;
  logic [7:0]       dd_wdata, cg_wdata;
  logic             rd_en_c;
  logic [7:0]       rd_data_c;

  // DDRAM address decode: two 40-cell lines when N=1, one 80-cell line when N=0
  function automatic logic dd_valid(input logic [6:0] a, input logic n);
    if (n) return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    return a <= 7'h4F;
  endfunction

  function automatic logic [6:0] dd_idx(input logic [6:0] a, input logic n);
    return (n && a[6]) ? 7'(a - 7'd24) : a;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic cg, input logic n,
                                         input logic inc);
    if (cg) return {1'b0, (inc ? 6'(a[5:0] + 6'd1) : 6'(a[5:0] - 6'd1))};
    if (n) begin
      if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : 7'(a + 7'd1);
      return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : 7'(a - 7'd1);
    end
    if (inc) return (a == 7'h4F) ? 7'h00 : 7'(a + 7'd1);
    return (a == 7'h00) ? 7'h4F : 7'(a - 7'd1);
  endfunction

  function automatic logic [5:0] shift_step(input logic [5:0] s, input logic inc);
    if (inc) return (s == 6'(SHIFT_MOD - 1)) ? 6'd0 : 6'(s + 6'd1);
    return (s == 6'd0) ? 6'(SHIFT_MOD - 1) : 6'(s - 6'd1);
  endfunction

  assign commit_c    = e_q & ~lcd.LCD_E;
  assign wr_commit_c = commit_c & ~rw_q;
`ifdef LCD_RESP_BUSY_CHECK_EN
  assign drop_c      = wr_commit_c & busy_q;
`else
  assign drop_c      = 1'b0;
`endif
  assign wr_ok_c     = wr_commit_c & ~drop_c;

  // Read path: status or RAM byte, driven only during a read strobe
  assign rd_en_c = lcd.LCD_E & lcd.LCD_RW;
  always_comb begin
    rd_data_c = 8'h20;
    if (!lcd.LCD_RS)             rd_data_c = {busy_q, ac_q};
    else if (ac_cg_q)            rd_data_c = cgram_q[ac_q[5:0]];
    else if (dd_valid(ac_q, n_q)) rd_data_c = ddram_q[dd_idx(ac_q, n_q)];
  end
  assign LCD_data = rd_en_c ? rd_data_c : 8'bzzzz_zzzz;

  assign lcd.dbg_data = dd_valid(lcd.dbg_addr, n_q) ? ddram_q[dd_idx(lcd.dbg_addr, n_q)] : 8'h20;
  assign lcd.ac           = ac_q;
  assign lcd.busy         = busy_q;
  assign lcd.disp_on      = d_q;
  assign lcd.cursor_on    = c_q;
  assign lcd.blink_on     = b_q;
  assign lcd.two_line     = n_q;
  assign lcd.shift_ofs    = shift_q;
  assign lcd.protocol_err = perr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sweep_idx_q <= '0;
      busy_cnt_q  <= '0;
      busy_q      <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      ac_q        <= '0;
      ac_cg_q     <= 1'b0;
      id_q        <= 1'b1;
      s_q         <= 1'b0;
      d_q         <= 1'b0;
      c_q         <= 1'b0;
      b_q         <= 1'b0;
      n_q         <= 1'b0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      busy_cnt_q  <= busy_cnt_d;
      busy_q      <= busy_d;
      e_q         <= lcd.LCD_E;
      if (lcd.LCD_E) begin
        rs_q   <= lcd.LCD_RS;
        rw_q   <= lcd.LCD_RW;
        data_q <= LCD_data;
      end
      ac_q    <= ac_d;
      ac_cg_q <= ac_cg_d;
      id_q    <= id_d;
      s_q     <= s_d;
      d_q     <= d_d;
      c_q     <= c_d;
      b_q     <= b_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
    end
  end

  // RAM contents survive reset; a user write in the same cycle wins over the clear sweep
  always_ff @(posedge clk) begin
    if (reset_n && sw_we) ddram_q[sw_idx]  <= 8'h20;
    if (reset_n && dd_we) ddram_q[dd_widx] <= dd_wdata;
    if (reset_n && cg_we) cgram_q[cg_waddr] <= cg_wdata;
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    busy_cnt_d  = (busy_cnt_q != '0) ? CNT_W'(busy_cnt_q - CNT_W'(1)) : '0;
    ac_d        = ac_q;
    ac_cg_d     = ac_cg_q;
    id_d        = id_q;
    s_d         = s_q;
    d_d         = d_q;
    c_d         = c_q;
    b_d         = b_q;
    n_d         = n_q;
    shift_d     = shift_q;
    perr_d      = perr_q | drop_c;
    dd_we       = 1'b0;
    dd_widx     = '0;
    dd_wdata    = '0;
    cg_we       = 1'b0;
    cg_waddr    = '0;
    cg_wdata    = '0;
    sw_we       = 1'b0;
    sw_idx      = '0;

    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_CLEAR: begin
        sw_we  = 1'b1;
        sw_idx = sweep_idx_q;
        if (sweep_idx_q == 7'(DD_CELLS - 1)) state_d = ST_IDLE;
        else sweep_idx_d = 7'(sweep_idx_q + 7'd1);
      end
    endcase

    if (wr_ok_c) begin
      busy_cnt_d = CNT_W'(BUSY_CYCLES);
      if (!rs_q) begin
        // Instruction decode by highest set bit
        casez (data_q)
          8'b1???_????: begin ac_d = data_q[6:0]; ac_cg_d = 1'b0; end
          8'b01??_????: begin ac_d = {1'b0, data_q[5:0]}; ac_cg_d = 1'b1; end
          8'b001?_????: n_d = data_q[3];
          8'b0001_????: begin
            if (data_q[3]) shift_d = shift_step(shift_q, data_q[2]);
            else           ac_d    = ac_step(ac_q, ac_cg_q, n_q, data_q[2]);
          end
          8'b0000_1???: begin d_d = data_q[2]; c_d = data_q[1]; b_d = data_q[0]; end
          8'b0000_01??: begin id_d = data_q[1]; s_d = data_q[0]; end
          8'b0000_001?: begin
            ac_d       = '0;
            ac_cg_d    = 1'b0;
            shift_d    = '0;
            busy_cnt_d = CNT_W'(BUSY_LONG_CYCLES);
          end
          8'b0000_0001: begin
            ac_d        = '0;
            ac_cg_d     = 1'b0;
            id_d        = 1'b1;
            shift_d     = '0;
            busy_cnt_d  = CNT_W'(CLEAR_CYCLES);
            state_d     = ST_CLEAR;
            sweep_idx_d = '0;
          end
          default: ;
        endcase
      end else begin
        if (ac_cg_q) begin
          cg_we    = 1'b1;
          cg_waddr = ac_q[5:0];
          cg_wdata = data_q;
        end else if (dd_valid(ac_q, n_q)) begin
          dd_we    = 1'b1;
          dd_widx  = dd_idx(ac_q, n_q);
          dd_wdata = data_q;
        end
        ac_d = ac_step(ac_q, ac_cg_q, n_q, id_q);
        if (s_q) shift_d = shift_step(shift_q, id_q);
      end
    end else if (commit_c && rw_q && rs_q) begin
      ac_d = ac_step(ac_q, ac_cg_q, n_q, id_q);
    end

    busy_d = (busy_cnt_d != '0);
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed self-checking bench for lcd_hd44780_responder (default parameters).
module tb_lcd_hd44780_responder;

  logic       clk;
  logic       reset_n;
  logic [7:0] tb_dout;
  logic       tb_oe;
  wire  [7:0] lcd_data;
  int         checks = 0;
  int         errors = 0;

  lcd_hd44780_responder_if lcd ();

  assign lcd_data = tb_oe ? tb_dout : 8'bzzzz_zzzz;

  lcd_hd44780_responder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .lcd      (lcd.slave),
    .LCD_data (lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle E pulse; returns one cycle after the committing edge
  task automatic lcd_write(input logic rs, input logic [7:0] d);
    lcd.LCD_E = 1'b1; lcd.LCD_RS = rs; lcd.LCD_RW = 1'b0;
    tb_dout = d; tb_oe = 1'b1;
    tick();
    lcd.LCD_E = 1'b0; tb_oe = 1'b0;
    tick();
  endtask

  task automatic lcd_read(input logic rs, output logic [7:0] d);
    lcd.LCD_E = 1'b1; lcd.LCD_RS = rs; lcd.LCD_RW = 1'b1;
    #1 d = lcd_data;
    tick();
    lcd.LCD_E = 1'b0; lcd.LCD_RW = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && lcd.busy; i++) tick();
    if (lcd.busy) chk("idle_timeout", 16'(lcd.busy), 16'h0);
  endtask

  task automatic dbg(input logic [6:0] a, output logic [7:0] d);
    lcd.dbg_addr = a;
    #1 d = lcd.dbg_data;
  endtask

  logic [7:0] rd;
  int         n;
  int         bad;

  initial begin
    reset_n = 1'b0; tb_oe = 1'b0; tb_dout = '0;
    lcd.LCD_E = 1'b0; lcd.LCD_RS = 1'b0; lcd.LCD_RW = 1'b0; lcd.dbg_addr = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    chk("rst_ac", 16'(lcd.ac), 16'h0);
    chk("rst_busy", 16'(lcd.busy), 16'h0);
    chk("rst_dcb", 16'({lcd.disp_on, lcd.cursor_on, lcd.blink_on}), 16'h0);
    chk("rst_n", 16'(lcd.two_line), 16'h0);
    chk("rst_shift", 16'(lcd.shift_ofs), 16'h0);
    chk("rst_perr", 16'(lcd.protocol_err), 16'h0);
    lcd_read(1'b0, rd);
    chk("rst_status", 16'(rd), 16'h00);

    // Busy window after an ordinary instruction: 40 cycles of {1,AC=0}
    lcd_write(1'b0, 8'h80);
    lcd.LCD_E = 1'b1; lcd.LCD_RS = 1'b0; lcd.LCD_RW = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1 chk("status_busy", 16'(lcd_data), 16'h80);
      tick();
    end
    #1 chk("status_done", 16'(lcd_data), 16'h00);
    lcd.LCD_E = 1'b0; lcd.LCD_RW = 1'b0;
    tick(); tick();

    lcd_write(1'b0, 8'h38);
    chk("fset_n1", 16'(lcd.two_line), 16'h1);
    wait_idle();
    lcd_write(1'b0, 8'hA7);
    chk("set_ac27", 16'(lcd.ac), 16'h27);
    wait_idle();
    lcd_write(1'b1, 8'h41);
    dbg(7'h27, rd);
    chk("dd27", 16'(rd), 16'h41);
    chk("wrap27_40", 16'(lcd.ac), 16'h40);
    wait_idle();

    lcd_write(1'b0, 8'h80); wait_idle();
    lcd_write(1'b1, 8'h41); wait_idle();
    lcd_write(1'b1, 8'h42); wait_idle();
    lcd_write(1'b0, 8'h80); wait_idle();
    lcd_read(1'b1, rd);
    chk("rd0", 16'(rd), 16'h41);
    lcd_read(1'b1, rd);
    chk("rd1", 16'(rd), 16'h42);
    chk("rd_ac", 16'(lcd.ac), 16'h02);

    lcd_write(1'b0, 8'h0F);
    chk("dcb_f", 16'({lcd.disp_on, lcd.cursor_on, lcd.blink_on}), 16'h7);
    wait_idle();
    lcd_write(1'b0, 8'h0A);
    chk("dcb_a", 16'({lcd.disp_on, lcd.cursor_on, lcd.blink_on}), 16'h2);
    wait_idle();

    lcd_write(1'b0, 8'h10);
    chk("cur_left", 16'(lcd.ac), 16'h01);
    wait_idle();
    lcd_write(1'b0, 8'h14);
    chk("cur_right", 16'(lcd.ac), 16'h02);
    wait_idle();
    lcd_write(1'b0, 8'h80); wait_idle();
    lcd_write(1'b0, 8'h10);
    chk("cur_wrap00_67", 16'(lcd.ac), 16'h67);
    wait_idle();
    lcd_write(1'b0, 8'h14);
    chk("cur_wrap67_00", 16'(lcd.ac), 16'h00);
    wait_idle();

    // Clear: long busy, then every mapped cell reads as a space
    lcd_write(1'b0, 8'h01);
    n = 0;
    while (lcd.busy && n < 3000) begin
      n++;
      tick();
    end
    chk("clear_busy_len", 16'(n), 16'd1640);
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) begin
        dbg(7'(a), rd);
        if (rd !== 8'h20) bad++;
      end
    end
    tick();
    chk("clear_cells", 16'(bad), 16'h0);
    chk("clear_ac", 16'(lcd.ac), 16'h0);
    chk("clear_shift", 16'(lcd.shift_ofs), 16'h0);

    lcd_write(1'b0, 8'h07); wait_idle();
    lcd_write(1'b1, 8'h55);
    chk("ent_shift", 16'(lcd.shift_ofs), 16'h1);
    chk("ent_ac", 16'(lcd.ac), 16'h01);
    wait_idle();
    lcd_write(1'b0, 8'h02);
    chk("home_shift", 16'(lcd.shift_ofs), 16'h0);
    chk("home_ac", 16'(lcd.ac), 16'h0);
    wait_idle();
    lcd_write(1'b0, 8'h18);
    chk("dshift_wrap", 16'(lcd.shift_ofs), 16'd39);
    chk("dshift_ac", 16'(lcd.ac), 16'h0);
    wait_idle();
    lcd_write(1'b0, 8'h1C);
    chk("dshift_back", 16'(lcd.shift_ofs), 16'd0);
    wait_idle();

    lcd_write(1'b0, 8'h06); wait_idle();
    lcd_write(1'b0, 8'h7F);
    chk("cg_ac", 16'(lcd.ac), 16'h3F);
    wait_idle();
    lcd_write(1'b1, 8'hAA);
    chk("cg_wrap", 16'(lcd.ac), 16'h00);
    chk("cg_noshift", 16'(lcd.shift_ofs), 16'h0);
    wait_idle();
    lcd_write(1'b0, 8'h7F); wait_idle();
    lcd_read(1'b1, rd);
    chk("cg_rd", 16'(rd), 16'hAA);
    chk("cg_rd_ac", 16'(lcd.ac), 16'h00);

    lcd_write(1'b0, 8'h30);
    chk("fset_n0", 16'(lcd.two_line), 16'h0);
    wait_idle();
    lcd_write(1'b0, 8'hCF); wait_idle();
    lcd_write(1'b1, 8'h33);
    chk("n0_wrap", 16'(lcd.ac), 16'h00);
    dbg(7'h4F, rd);
    chk("n0_dd4f", 16'(rd), 16'h33);
    wait_idle();
    lcd_write(1'b0, 8'hB0); wait_idle();
    lcd_write(1'b1, 8'h5A);
    dbg(7'h30, rd);
    chk("n0_dd30", 16'(rd), 16'h5A);
    chk("n0_ac31", 16'(lcd.ac), 16'h31);
    wait_idle();
    lcd_write(1'b0, 8'h38);
    dbg(7'h30, rd);
    chk("n1_unmapped", 16'(rd), 16'h20);
    dbg(7'h48, rd);
    chk("n1_dd48", 16'(rd), 16'h5A);
    wait_idle();

    // Data write landing inside the busy window of the preceding instruction
    lcd_write(1'b0, 8'h80); wait_idle();
    lcd_write(1'b1, 8'h11); wait_idle();
    lcd_write(1'b0, 8'h80);
    lcd_write(1'b1, 8'h99);
    dbg(7'h00, rd);
`ifdef LCD_RESP_BUSY_CHECK_EN
    chk("busy_wr_dd", 16'(rd), 16'h11);
    chk("busy_wr_perr", 16'(lcd.protocol_err), 16'h1);
    chk("busy_wr_ac", 16'(lcd.ac), 16'h00);
`else
    chk("busy_wr_dd", 16'(rd), 16'h99);
    chk("busy_wr_perr", 16'(lcd.protocol_err), 16'h0);
    chk("busy_wr_ac", 16'(lcd.ac), 16'h01);
`endif
    wait_idle();

    // Reset in the middle of a clear sweep
    lcd_write(1'b0, 8'h01);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    chk("rst_sweep_busy", 16'(lcd.busy), 16'h0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rst_sweep_busy2", 16'(lcd.busy), 16'h0);
    chk("rst_sweep_perr", 16'(lcd.protocol_err), 16'h0);
    chk("rst_sweep_n", 16'(lcd.two_line), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
